ecc_op_controller: RTL and testbench



---
 rtl/ecc_op_controller.sv | 135 +++++++++++++
 tb/tb_ecc_op_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_op_controller.sv
// Sequences one ECC datapath operation per CTRL write: latch operands, validate, launch, wait for done (with timeout), capture result.
// Latency: dp_start one cycle after ctrl_wr, op_done one cycle after dp_done; no backpressure, ctrl_wr while busy is dropped and flagged as overrun.
module ecc_op_controller #(
    parameter int AMBA_WORD      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_wr,
    input  logic [AMBA_WORD-1:0]  ctrl,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [AMBA_WORD-1:0]  codeword_width,
    input  logic [DATA_WIDTH-1:0] noise,
    output logic                  dp_start,
    output logic                  dp_abort,
    output logic [1:0]            dp_mode,
    output logic [1:0]            dp_width,
    output logic [DATA_WIDTH-1:0] dp_data,
    output logic [DATA_WIDTH-1:0] dp_noise,
    input  logic                  dp_done,
    input  logic [DATA_WIDTH-1:0] dp_data_out,
    input  logic [1:0]            dp_num_err,
    output logic                  busy,
    output logic                  op_done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            num_of_errors,
    output logic [3:0]            status
);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMPLETE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [1:0]            width_q, width_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] noise_q, noise_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [1:0]            nerr_q, nerr_d;
    logic [3:0]            status_q, status_d;
    logic                  cmd_bad;
    logic                  unused_upper_bits;

    assign unused_upper_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};
    assign cmd_bad           = |status_q[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= '0;
            width_q  <= '0;
            data_q   <= '0;
            noise_q  <= '0;
            dout_q   <= '0;
            nerr_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            width_q  <= width_d;
            data_q   <= data_d;
            noise_q  <= noise_d;
            dout_q   <= dout_d;
            nerr_q   <= nerr_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        width_d  = width_q;
        data_d   = data_q;
        noise_d  = noise_q;
        dout_d   = dout_q;
        nerr_d   = nerr_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_wr) begin
                    mode_d   = ctrl[1:0];
                    width_d  = codeword_width[1:0];
                    data_d   = data_in;
                    noise_d  = noise;
                    status_d = {2'b00, &codeword_width[1:0], &ctrl[1:0]};
                    state_d  = S_LAUNCH;
                end
            end
            // An illegal command still spends this cycle here, with dp_start suppressed,
            // so its op_done lands two cycles after the write.
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = cmd_bad ? S_COMPLETE : S_WAIT;
            end
            S_WAIT: begin
                if (dp_done) begin
                    dout_d  = dp_data_out;
                    nerr_d  = dp_num_err;
                    state_d = S_COMPLETE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        status_d[2] = 1'b1;
                        dout_d      = '0;
                        nerr_d      = '0;
                        state_d     = S_COMPLETE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (ctrl_wr && (state_q != S_IDLE)) begin
            status_d[3] = 1'b1;
        end
    end

    assign dp_start      = (state_q == S_LAUNCH) && !cmd_bad;
    assign op_done       = (state_q == S_COMPLETE);
    assign dp_abort      = (state_q == S_COMPLETE) && status_q[2];
    assign busy          = (state_q != S_IDLE);
    assign dp_mode       = mode_q;
    assign dp_width      = width_q;
    assign dp_data       = data_q;
    assign dp_noise      = noise_q;
    assign data_out      = dout_q;
    assign num_of_errors = nerr_q;
    assign status        = status_q;

endmodule

// File: tb/tb_ecc_op_controller.sv
// Scoreboarded bench for ecc_op_controller: a driver emulates the APB side and the datapath,
// a cycle-level reference model predicts every launch and completion, and a monitor compares.
module tb_ecc_op_controller;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_wr = 1'b0;
    logic [31:0] ctrl = '0;
    logic [31:0] data_in = '0;
    logic [31:0] codeword_width = '0;
    logic [31:0] noise = '0;
    logic        dp_start, dp_abort;
    logic [1:0]  dp_mode, dp_width;
    logic [31:0] dp_data, dp_noise;
    logic        dp_done = 1'b0;
    logic [31:0] dp_data_out = '0;
    logic [1:0]  dp_num_err = '0;
    logic        busy, op_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic [3:0]  status;

    ecc_op_controller #(.AMBA_WORD(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .ctrl_wr(ctrl_wr), .ctrl(ctrl), .data_in(data_in),
        .codeword_width(codeword_width), .noise(noise), .dp_start(dp_start),
        .dp_abort(dp_abort), .dp_mode(dp_mode), .dp_width(dp_width), .dp_data(dp_data),
        .dp_noise(dp_noise), .dp_done(dp_done), .dp_data_out(dp_data_out),
        .dp_num_err(dp_num_err), .busy(busy), .op_done(op_done), .data_out(data_out),
        .num_of_errors(num_of_errors), .status(status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [1:0]  mode;
        logic [1:0]  width;
        logic [31:0] data;
        logic [31:0] noise;
    } sexp_t;

    typedef struct {
        int          cyc;
        logic [31:0] dout;
        logic [1:0]  err;
        logic [3:0]  st;
        logic        abort;
        logic [31:0] dpd;
    } dexp_t;

    sexp_t       start_q[$];
    dexp_t       done_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;
    int          bs = 1;
    int          be = 0;
    logic [31:0] mdata = '0;
    logic [1:0]  merr = '0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            sexp_t s;
            dexp_t d;
            chk("busy", 64'(busy), 64'(cyc >= bs && cyc <= be));
            if (dp_start) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_dp_start", 64'(dp_start), 64'(0));
                end else begin
                    s = start_q.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(s.cyc));
                    chk("dp_mode", 64'(dp_mode), 64'(s.mode));
                    chk("dp_width", 64'(dp_width), 64'(s.width));
                    chk("dp_data", 64'(dp_data), 64'(s.data));
                    chk("dp_noise", 64'(dp_noise), 64'(s.noise));
                end
            end
            if (op_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_op_done", 64'(op_done), 64'(0));
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d.cyc));
                    chk("data_out", 64'(data_out), 64'(d.dout));
                    chk("num_of_errors", 64'(num_of_errors), 64'(d.err));
                    chk("status", 64'(status), 64'(d.st));
                    chk("dp_abort", 64'(dp_abort), 64'(d.abort));
                    chk("dp_data_held", 64'(dp_data), 64'(d.dpd));
                    chk("start_pending", 64'(start_q.size()), 64'(0));
                end
            end else if (dp_abort) begin
                chk("abort_without_done", 64'(dp_abort), 64'(0));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    // dly: WAIT-cycle index (1-based) on which dp_done arrives, 0 = never.
    // rst_at: cycle offset from the write at which reset is pulsed, 0 = no reset.
    task automatic do_op(input logic [1:0] m, input logic [1:0] w, input logic [31:0] d,
                         input logic [31:0] nz, input logic [31:0] rd, input logic [1:0] re,
                         input int dly, input bit want_ov, input int rst_at, input bit launch_done);
        int    n, e, ov_at;
        bit    bad, ok_done;
        dexp_t x;
        wait_idle();
        n       = cyc;
        bad     = (m == 2'd3) || (w == 2'd3);
        ok_done = !bad && dly >= 1 && dly <= T;
        e       = bad ? n + 2 : (ok_done ? n + 2 + dly : n + 2 + T);
        if (rst_at > 0) e = n + rst_at;
        ov_at   = (want_ov && rst_at == 0) ? int'($urandom_range(1, e - n - 1)) : 0;
        if (!bad) start_q.push_back('{n + 1, m, w, d, nz});
        if (rst_at == 0) begin
            if (!bad) begin
                mdata = ok_done ? rd : 32'd0;
                merr  = ok_done ? re : 2'd0;
            end
            x = '{e, mdata, merr, {ov_at > 0, !bad && !ok_done, w == 2'd3, m == 2'd3},
                  !bad && !ok_done, d};
            done_q.push_back(x);
        end
        bs = n + 1;
        be = e;
        ctrl_wr        = 1'b1;
        ctrl           = $urandom;
        ctrl[1:0]      = m;
        codeword_width = $urandom;
        codeword_width[1:0] = w;
        data_in        = d;
        noise          = nz;
        @(negedge clk);
        while (cyc <= e) begin
            dp_done     = 1'b0;
            dp_data_out = $urandom;
            dp_num_err  = 2'($urandom_range(0, 2));
            if (ok_done && cyc == n + 1 + dly) begin
                dp_done     = 1'b1;
                dp_data_out = rd;
                dp_num_err  = re;
            end
            if (launch_done && cyc == n + 1) dp_done = 1'b1;
            ctrl_wr = (ov_at > 0) && (cyc == n + ov_at);
            if (ctrl_wr) begin
                data_in = ~d;
                noise   = ~nz;
                ctrl    = $urandom;
            end
            rst = (rst_at > 0) && (cyc == n + rst_at);
            @(negedge clk);
        end
        dp_done = 1'b0;
        ctrl_wr = 1'b0;
        rst     = 1'b0;
        if (rst_at > 0) begin
            mdata = '0;
            merr  = '0;
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_status", 64'(status), 64'(0));
            chk("rst_data_out", 64'(data_out), 64'(0));
            chk("rst_num_err", 64'(num_of_errors), 64'(0));
            chk("rst_op_done", 64'(op_done), 64'(0));
            chk("rst_dp_abort", 64'(dp_abort), 64'(0));
            chk("rst_dp_data", 64'(dp_data), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_op_done", 64'(op_done), 64'(0));
        chk("reset_dp_start", 64'(dp_start), 64'(0));
        chk("reset_dp_abort", 64'(dp_abort), 64'(0));
        chk("reset_status", 64'(status), 64'(0));
        chk("reset_data_out", 64'(data_out), 64'(0));
        chk("reset_num_err", 64'(num_of_errors), 64'(0));
        chk("reset_dp_ops", 64'({dp_mode, dp_width, dp_data, dp_noise}), 64'(0));
        rst    = 1'b0;
        mon_en = 1'b1;
        while (cyc < 10) @(negedge clk);

        do_op(2'd0, 2'd1, 32'hA5, 32'h0, 32'h1A5C, 2'd0, 3, 1'b0, 0, 1'b0);
        do_op(2'd1, 2'd0, $urandom, $urandom, $urandom, 2'd2, 1, 1'b0, 0, 1'b0);
        do_op(2'd3, 2'd3, $urandom, $urandom, $urandom, 2'd1, 2, 1'b0, 0, 1'b0);
        do_op(2'd2, 2'd2, $urandom, $urandom, $urandom, 2'd1, 0, 1'b0, 0, 1'b0);
        do_op(2'd2, 2'd1, $urandom, $urandom, $urandom, 2'd1, T, 1'b0, 0, 1'b0);
        do_op(2'd1, 2'd2, $urandom, $urandom, $urandom, 2'd1, 8, 1'b1, 0, 1'b0);
        do_op(2'd0, 2'd0, $urandom, $urandom, $urandom, 2'd0, 2, 1'b0, 0, 1'b0);
        do_op(2'd1, 2'd1, $urandom, $urandom, $urandom, 2'd0, 0, 1'b0, 5, 1'b0);
        do_op(2'd0, 2'd2, $urandom, $urandom, $urandom, 2'd2, 2, 1'b0, 0, 1'b0);
        do_op(2'd1, 2'd0, $urandom, $urandom, $urandom, 2'd1, 4, 1'b0, 0, 1'b1);
        do_op(2'd3, 2'd0, $urandom, $urandom, $urandom, 2'd1, 1, 1'b0, 0, 1'b0);
        do_op(2'd0, 2'd3, $urandom, $urandom, $urandom, 2'd1, 1, 1'b1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom, 2'($urandom_range(0, 2)), int'($urandom_range(0, T)),
                  $urandom_range(0, 3) == 0, 0, $urandom_range(0, 3) == 0);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("start_q_drained", 64'(start_q.size()), 64'(0));
        chk("done_q_drained", 64'(done_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
